mem_axi_req_unit: RTL

MEM-stage AXI data-side initiator. Takes the load/store held in the EXE->MEM pipeline

---
 rtl/cpu_axi_pkg.sv | 27 ++
 rtl/mem_axi_req_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cpu_axi_pkg.sv
// Shared types for the MEM-stage AXI data-side initiator: FSM states, AXI size and response encodings.
package cpu_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } axi_state_e;

    localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
    localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    // Pipeline size code (0/1/2) to AXI AxSIZE; only up to word accesses exist.
    function automatic logic [2:0] to_axi_size(input logic [1:0] req_size);
        return {1'b0, req_size};
    endfunction

endpackage

// File: rtl/mem_axi_req_unit.sv
// Single-beat AXI read/write initiator for the MEM stage; stalls the EXE->MEM register via axi_block until the access completes.
// Load or store with zero-wait channels reaches rsp_valid 3 cycles after capture; any AXI wait extends the stall.
module mem_axi_req_unit
    import cpu_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_wr,
    input  logic [1:0]          req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic                req_adv,
    output logic                axi_block,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [2:0]          m_size,
    output logic                ar_valid,
    input  logic                ar_ready,
    input  logic                r_valid,
    output logic                r_ready,
    input  logic [DATA_W-1:0]   r_data,
    output logic                aw_valid,
    input  logic                aw_ready,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [DATA_W-1:0]   w_data,
    output logic [DATA_W/8-1:0] w_strb,
    input  logic                b_valid,
    output logic                b_ready
);

    axi_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        axi_block = 1'b0;
        rsp_valid = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                axi_block = req_valid;
                if (req_valid) begin
                    addr_d    = req_addr;
                    size_d    = to_axi_size(req_size);
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_wr ? ST_WR_REQ : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                axi_block = 1'b1;
                ar_valid  = 1'b1;
                if (ar_ready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                axi_block = 1'b1;
                r_ready   = 1'b1;
                if (r_valid) begin
                    rdata_d = r_data;
                    state_d = ST_DONE;
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; both may complete in the same cycle.
                axi_block = 1'b1;
                aw_valid  = !aw_done_q;
                w_valid   = !w_done_q;
                aw_done_d = aw_done_q | aw_ready;
                w_done_d  = w_done_q | w_ready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                axi_block = 1'b1;
                b_ready   = 1'b1;
                if (b_valid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hold until the pipeline advances so a stalled token is never reissued.
                rsp_valid = 1'b1;
                if (req_adv) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_addr    = addr_q;
    assign m_size    = size_q;
    assign w_data    = wdata_q;
    assign w_strb    = wstrb_q;
    assign rsp_rdata = rdata_q;

endmodule
